// File: rtl/audio_cfg_pkg.sv
// Shared types and constants for the codec I2C initialiser.
// Holds the FSM state type and the register write table.
package audio_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        ACK,
        STOP,
        GAP,
        DONE,
        ERR
    } i2c_state_e;

    localparam int TABLE_DEPTH = 9;

    // Each entry is {reg[6:0], data[8:0]}, written first to last.
    localparam logic [15:0] INIT_TABLE [TABLE_DEPTH] = '{
        16'h1E00, 16'h0C00, 16'h0812,
        16'h0A00, 16'h0E02, 16'h1000,
        16'h0479, 16'h0679, 16'h1201
    };

    localparam logic [3:0] LAST_IDX = 4'(TABLE_DEPTH - 1);

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick divider for the I2C engine.
// tick is high for one clk at the terminal count CLK_DIV-1.
module i2c_tick_gen #(
    parameter int CLK_DIV = 70
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] TC = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == TC) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == TC);

endmodule

// File: rtl/audio_i2c_init.sv
// Codec register initialiser: writes INIT_TABLE over I2C after reset or start.
// Define AUDIO_I2C_ACK_CHECK_EN to stop on a NACK and flag err.
module audio_i2c_init
    import audio_cfg_pkg::*;
#(
    parameter int         CLK_DIV    = 70,
    parameter logic [6:0] DEV_ADDR   = 7'h1A,
    parameter int         GAP_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic i2c_sclk,
    inout  wire  i2c_sdat,
    output logic busy,
    output logic done,
    output logic err
);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_END = GW'(GAP_CYCLES);

    i2c_state_e    state, state_n;
    logic [1:0]    q, q_n;
    logic [2:0]    bcnt, bcnt_n;
    logic [1:0]    byt, byt_n;
    logic [3:0]    idx, idx_n;
    logic [GW-1:0] gcnt, gcnt_n;
    logic          nack, nack_n;
    logic          tick, ack_fail;
    logic          scl_d, sda_lo_d, sda_lo;
    logic [15:0]   word_n;
    logic [7:0]    byte_n;

    i2c_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

`ifdef AUDIO_I2C_ACK_CHECK_EN
    assign ack_fail = i2c_sdat;
    assign err      = (state == ERR);
`else
    assign ack_fail = 1'b0;
    assign err      = 1'b0;
`endif

    assign i2c_sdat = sda_lo ? 1'b0 : 1'bz;
    assign busy     = state inside {START, SHIFT, ACK, STOP, GAP};
    assign done     = (state == DONE);

    // q starts at 3 so the very first tick after reset launches START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            q        <= 2'd3;
            bcnt     <= '0;
            byt      <= '0;
            idx      <= '0;
            gcnt     <= '0;
            nack     <= 1'b0;
            i2c_sclk <= 1'b1;
            sda_lo   <= 1'b0;
        end else begin
            state    <= state_n;
            q        <= q_n;
            bcnt     <= bcnt_n;
            byt      <= byt_n;
            idx      <= idx_n;
            gcnt     <= gcnt_n;
            nack     <= nack_n;
            i2c_sclk <= scl_d;
            sda_lo   <= sda_lo_d;
        end
    end

    always_comb begin
        state_n = state;
        q_n     = q;
        bcnt_n  = bcnt;
        byt_n   = byt;
        idx_n   = idx;
        nack_n  = nack;
        gcnt_n  = (state == GAP && gcnt != GAP_END) ? gcnt + 1'b1 : gcnt;
        if (start) begin
            state_n = IDLE;
            q_n     = 2'd0;
            bcnt_n  = '0;
            byt_n   = '0;
            idx_n   = '0;
            nack_n  = 1'b0;
            gcnt_n  = '0;
        end else if (tick) begin
            q_n = q + 2'd1;
            unique case (state)
                IDLE: begin
                    if (q == 2'd3) state_n = START;
                end
                START: begin
                    if (q == 2'd3) begin
                        state_n = SHIFT;
                        bcnt_n  = '0;
                        byt_n   = '0;
                        nack_n  = 1'b0;
                    end
                end
                SHIFT: begin
                    if (q == 2'd3) begin
                        bcnt_n = bcnt + 3'd1;
                        if (bcnt == 3'd7) state_n = ACK;
                    end
                end
                ACK: begin
                    if (q == 2'd2 && ack_fail) nack_n = 1'b1;
                    if (q == 2'd3) begin
                        if (nack || byt == 2'd2) begin
                            state_n = STOP;
                        end else begin
                            state_n = SHIFT;
                            byt_n   = byt + 2'd1;
                        end
                    end
                end
                STOP: begin
                    if (q == 2'd3) begin
                        state_n = nack ? ERR : GAP;
                        gcnt_n  = '0;
                    end
                end
                GAP: begin
                    q_n = 2'd0;
                    if (gcnt == GAP_END) begin
                        if (idx == LAST_IDX) begin
                            state_n = DONE;
                        end else begin
                            state_n = START;
                            idx_n   = idx + 4'd1;
                        end
                    end
                end
                DONE, ERR: q_n = q;
            endcase
        end
    end

    // Bus levels follow the next phase so SCL/SDA register in step with it.
    always_comb begin
        word_n = INIT_TABLE[idx_n];
        unique case (1'b1)
            (byt_n == 2'd0): byte_n = {DEV_ADDR, 1'b0};
            (byt_n == 2'd1): byte_n = word_n[15:8];
            default:         byte_n = word_n[7:0];
        endcase
        scl_d    = 1'b1;
        sda_lo_d = 1'b0;
        unique case (state_n)
            START: begin
                scl_d    = (q_n != 2'd3);
                sda_lo_d = q_n[1];
            end
            SHIFT: begin
                scl_d    = (q_n == 2'd1) || (q_n == 2'd2);
                sda_lo_d = !byte_n[3'd7 - bcnt_n];
            end
            ACK: begin
                scl_d = (q_n == 2'd1) || (q_n == 2'd2);
            end
            STOP: begin
                scl_d    = (q_n != 2'd0);
                sda_lo_d = !q_n[1];
            end
            default: begin
                scl_d    = 1'b1;
                sda_lo_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_audio_i2c_init.sv
// Bench for audio_i2c_init: I2C slave/monitor with a frame scoreboard.
// Honours AUDIO_I2C_ACK_CHECK_EN to exercise the NACK path.
module tb_audio_i2c_init;
    localparam int DIV    = 4;
    localparam int GAP    = 16;
    localparam int BUDGET = 12000;
    localparam logic [15:0] TBL [9] = '{
        16'h1E00, 16'h0C00, 16'h0812,
        16'h0A00, 16'h0E02, 16'h1000,
        16'h0479, 16'h0679, 16'h1201
    };

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start2 = 1'b0;
    logic scl, scl2, busy, busy2, done, done2, err, err2;
    wire  sda, sda2;
    logic slave_low = 1'b0;

    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    logic [31:0] exp_q [$];

    bit          in_frame = 0;
    bit          have_stop = 0;
    bit          nack_armed = 0;
    bit          meas_done = 0;
    int          mbits = 0;
    int          nfull = 0;
    int          stop_cyc = 0;
    logic [23:0] mdata = '0;
    logic [2:0]  macks = '0;

    audio_i2c_init #(
        .CLK_DIV   (DIV),
        .DEV_ADDR  (7'h1A),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .i2c_sclk(scl),
        .i2c_sdat(sda),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    audio_i2c_init #(
        .CLK_DIV   (70),
        .DEV_ADDR  (7'h1A),
        .GAP_CYCLES(GAP)
    ) dut_t (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start2),
        .i2c_sclk(scl2),
        .i2c_sdat(sda2),
        .busy    (busy2),
        .done    (done2),
        .err     (err2)
    );

    assign sda = slave_low ? 1'b0 : 1'bz;
    pullup (sda);
    pullup (sda2);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic chk_ge(input string nm, input int act, input int lo);
        total++;
        if (act >= lo) passed++;
        else $display("FAIL %s: got %0d, expected >= %0d", nm, act, lo);
    endtask

    task automatic push_seq(input int n, input int nack_frame);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({5'd0, (i == nack_frame) ? 3'b001 : 3'b000,
                             8'h34, TBL[i]});
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (done !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done"}, done, 1);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_err"}, err, 0);
    endtask

    // Bus monitor: START/STOP detection and scoreboard compare.
    always @(sda) begin
        if (scl === 1'b1) begin
            if (sda === 1'b0) begin
                if (have_stop) chk_ge("gap_clk", cyc - stop_cyc, GAP + 8);
                have_stop = 0;
                in_frame  = 1;
                mbits     = 0;
                mdata     = '0;
                macks     = '0;
            end else if (in_frame) begin
                in_frame = 0;
                if (mbits == 27) begin
                    nfull++;
                    stop_cyc  = cyc;
                    have_stop = 1;
                    if (exp_q.size() == 0) begin
                        total++;
                        $display("FAIL frame_extra: got %h, expected none",
                                 {5'd0, macks, mdata});
                    end else begin
                        chk($sformatf("frame_%0d", nfull),
                            {5'd0, macks, mdata}, exp_q.pop_front());
                    end
                end
            end
        end
    end

    always @(posedge scl) begin
        if (in_frame && mbits < 27) begin
            if (mbits % 9 == 8) macks = {macks[1:0], sda};
            else mdata = {mdata[22:0], sda};
            mbits++;
        end
    end

    // Slave: ACK every byte, except one injected NACK when armed.
    always @(negedge scl) begin
        if (in_frame && mbits % 9 == 8) begin
            if (nack_armed && nfull == 2 && mbits == 26) begin
                slave_low  = 1'b0;
                nack_armed = 0;
            end else begin
                slave_low = 1'b1;
            end
        end else begin
            slave_low = 1'b0;
        end
    end

    // SCL timing on the CLK_DIV=70 instance, first data bit.
    initial begin
        int n, t0, t1, t2;
        @(posedge rst_n);
        n = 0;
        while (scl2 !== 1'b0 && n < BUDGET) begin @(negedge clk); n++; end
        while (scl2 !== 1'b1 && n < BUDGET) begin @(negedge clk); n++; end
        t0 = cyc;
        while (scl2 !== 1'b0 && n < BUDGET) begin @(negedge clk); n++; end
        t1 = cyc;
        while (scl2 !== 1'b1 && n < BUDGET) begin @(negedge clk); n++; end
        t2 = cyc;
        chk("scl_period", t2 - t0, 280);
        chk("scl_high", t1 - t0, 140);
        meas_done = 1;
    end

    initial begin
        int n, base;
`ifdef AUDIO_I2C_ACK_CHECK_EN
        nack_armed = 1;
`endif
        repeat (3) @(negedge clk);
        chk("rst_scl", scl, 1);
        chk("rst_sda", sda, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);

`ifdef AUDIO_I2C_ACK_CHECK_EN
        push_seq(3, 2);
`else
        push_seq(9, -1);
`endif
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("run_busy", busy, 1);

`ifdef AUDIO_I2C_ACK_CHECK_EN
        n = 0;
        while (err !== 1'b1 && n < BUDGET) begin @(negedge clk); n++; end
        chk("nack_err", err, 1);
        chk("nack_done", done, 0);
        chk("nack_busy", busy, 0);
        repeat (1500) @(negedge clk);
        chk("nack_no_fourth", nfull, 3);
`else
        wait_done("boot");
        repeat (200) @(negedge clk);
        chk("done_held", done, 1);
`endif

        // Restart, then abort partway into frame 4.
        base = nfull;
        push_seq(3, -1);
        pulse_start();
        chk("restart_done", done, 0);
        chk("restart_err", err, 0);
        n = 0;
        while (!(nfull == base + 3 && in_frame && mbits >= 3) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached", n < BUDGET, 1);
        pulse_start();
        #1;
        chk("abort_scl", scl, 1);
        chk("abort_sda", sda, 1);
        chk("abort_busy", busy, 0);
        push_seq(9, -1);
        wait_done("abort");

        // Reset in the middle of frame 3.
        base = nfull;
        push_seq(2, -1);
        pulse_start();
        n = 0;
        while (!(nfull == base + 2 && in_frame && mbits >= 5) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("reset_reached", n < BUDGET, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_scl", scl, 1);
        chk("mid_rst_sda", sda, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        repeat (3) @(negedge clk);
        push_seq(9, -1);
        rst_n = 1'b1;
        wait_done("rerun");

        repeat (50) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("scl_meas_done", meas_done, 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
